// File: rtl/code_loader_pkg.sv
// -----------------------------------------------------------------------------
// code_loader_pkg
//   Shared constants, FSM state encoding and small helpers for the boot-time
//   code loader.
//   ADDR_W    : code memory address width
//   DATA_W    : instruction width (two bytes, MSB first)
//   MAX_WORDS : largest legal image in words (= 2**ADDR_W)
//   CNT_W     : width of the word/length counters (must hold MAX_WORDS)
// -----------------------------------------------------------------------------
package code_loader_pkg;

    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned MAX_WORDS = 64;
    localparam int unsigned CNT_W     = ADDR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StHi,
        StLo,
        StWrite,
        StCsum,
        StDone,
        StErr
    } state_e;

    // A length byte is legal when it names 1..MAX_WORDS words.
    function automatic logic len_ok(input logic [BYTE_W-1:0] n);
        return (n != '0) && (n <= BYTE_W'(MAX_WORDS));
    endfunction

endpackage

// File: rtl/code_loader_if.sv
// -----------------------------------------------------------------------------
// code_loader_if
//   Bundles the byte stream (valid/ready) feeding the loader and the code
//   memory write port driven by it.
//   byte_in/byte_valid/byte_ready : incoming byte stream
//   write_select/inp/write_en     : code memory write address/data/strobe
//   master : host side (drives the stream, observes the write port)
//   slave  : loader side (accepts the stream, drives the write port)
// -----------------------------------------------------------------------------
interface code_loader_if;
    import code_loader_pkg::*;

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] write_select;
    logic [DATA_W-1:0] inp;
    logic              write_en;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  write_select,
        input  inp,
        input  write_en
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output write_select,
        output inp,
        output write_en
    );

endinterface

// File: rtl/code_loader_byte_pack.sv
// -----------------------------------------------------------------------------
// code_loader_byte_pack
//   Latches the high byte of each word, assembles {hi, lo} when the low byte
//   arrives and keeps a running XOR checksum over every data byte.
//   clock, reset_n : clock and async active-low reset
//   clear          : zero the checksum (start of a new frame)
//   take_hi        : byte_in is the high byte of a word
//   take_lo        : byte_in is the low byte of a word
//   byte_in        : stream byte
//   word           : last fully assembled word (held until the next low byte)
//   csum           : XOR of all data bytes taken since the last clear
// -----------------------------------------------------------------------------
module code_loader_byte_pack
    import code_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              take_hi,
    input  logic              take_lo,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [DATA_W-1:0] word,
    output logic [BYTE_W-1:0] csum
);

    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [BYTE_W-1:0] csum_q, csum_d;

    always_comb begin
        hi_d   = hi_q;
        word_d = word_q;
        csum_d = csum_q;
        if (clear) begin
            csum_d = '0;
        end
        if (take_hi) begin
            hi_d   = byte_in;
            csum_d = csum_q ^ byte_in;
        end
        if (take_lo) begin
            word_d = {hi_q, byte_in};
            csum_d = csum_q ^ byte_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_q   <= '0;
            word_q <= '0;
            csum_q <= '0;
        end else begin
            hi_q   <= hi_d;
            word_q <= word_d;
            csum_q <= csum_d;
        end
    end

    assign word = word_q;
    assign csum = csum_q;

endmodule

// File: rtl/code_loader.sv
// -----------------------------------------------------------------------------
// code_loader
//   Boot-time writer for the 64x16 code memory. Takes a frame of
//   LEN, 2*LEN data bytes (hi, lo per word) and an XOR checksum byte from a
//   valid/ready byte stream, writes each word from address 0 upwards and holds
//   the CPU in reset until a complete, checksum-verified image is in memory.
//   clock, reset_n : clock and async active-low reset
//   start          : pulse to begin a load (ignored while busy)
//   abort          : synchronous return to idle, clears done/error
//   bus            : byte stream in, code memory write port out
//   busy           : load in progress
//   done           : image loaded with good checksum (sticky)
//   error          : bad length or checksum (sticky)
//   cpu_reset_n    : CPU reset release, equal to done
// -----------------------------------------------------------------------------
module code_loader
    import code_loader_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    code_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         cpu_reset_n
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] wsel_q, wsel_d;

    logic              take;
    logic              clear;
    logic              take_hi;
    logic              take_lo;
    logic [DATA_W-1:0] word;
    logic [BYTE_W-1:0] csum;

    code_loader_byte_pack u_byte_pack (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .take_hi (take_hi),
        .take_lo (take_lo),
        .byte_in (bus.byte_in),
        .word    (word),
        .csum    (csum)
    );

    assign take = bus.byte_valid && bus.byte_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        len_d   = len_q;
        wsel_d  = wsel_q;
        clear   = 1'b0;
        take_hi = 1'b0;
        take_lo = 1'b0;

        // Abort overrides everything, including a concurrent start or byte.
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state_d = StLen;
                        addr_d  = '0;
                        count_d = '0;
                        len_d   = '0;
                        clear   = 1'b1;
                    end
                end
                StLen: begin
                    if (take) begin
                        if (len_ok(bus.byte_in)) begin
                            len_d   = bus.byte_in[CNT_W-1:0];
                            state_d = StHi;
                        end else begin
                            state_d = StErr;
                        end
                    end
                end
                StHi: begin
                    if (take) begin
                        take_hi = 1'b1;
                        state_d = StLo;
                    end
                end
                StLo: begin
                    if (take) begin
                        take_lo = 1'b1;
                        wsel_d  = addr_q;
                        state_d = StWrite;
                    end
                end
                StWrite: begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    state_d = ((count_q + 1'b1) == len_q) ? StCsum : StHi;
                end
                StCsum: begin
                    if (take) begin
                        state_d = (bus.byte_in == csum) ? StDone : StErr;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            wsel_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            len_q   <= len_d;
            wsel_q  <= wsel_d;
        end
    end

    // Every output is a decode of registered state; byte_in never reaches the write port
    // combinationally.
    always_comb begin
        bus.byte_ready   = (state_q == StLen) || (state_q == StHi) ||
                           (state_q == StLo)  || (state_q == StCsum);
        bus.write_en     = (state_q == StWrite);
        bus.write_select = wsel_q;
        bus.inp          = word;
        busy             = bus.byte_ready || (state_q == StWrite);
        done             = (state_q == StDone);
        error            = (state_q == StErr);
        cpu_reset_n      = (state_q == StDone);
    end

endmodule

// File: tb/tb_code_loader.sv
module tb_code_loader;
    import code_loader_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clock;
    logic reset_n;
    logic start;
    logic abort;
    logic busy;
    logic done;
    logic error;
    logic cpu_reset_n;

    code_loader_if bus ();

    code_loader dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cpu_reset_n (cpu_reset_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_vec;
    int          n_err;
    int          cyc;
    int          wr_count;
    int          wr_cyc[$];
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [15:0] frame_w[64];
    bit          gap_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: checksum is the XOR of every data byte of the first n words.
    function automatic logic [7:0] ref_csum(input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ frame_w[i][15:8] ^ frame_w[i][7:0];
        return x;
    endfunction

    always @(posedge clock) cyc++;

    // Write-port monitor: every strobe must match the next expected (addr, data).
    always @(negedge clock) begin
        if (bus.write_en === 1'b1) begin
            wr_count++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("spurious_write_addr", 32'(bus.write_select), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.write_select), 32'(mon_e.addr));
                chk("wr_data", 32'(bus.inp), 32'(mon_e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clock);
        if (gap_en && $urandom_range(0, 3) == 0) begin
            bus.byte_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 16) begin
            @(negedge clock);
            t++;
        end
        if (bus.byte_ready !== 1'b1) chk("ready_timeout", 32'(bus.byte_ready), 32'd1);
        @(posedge clock);
    endtask

    task automatic send_word(input int i);
        exp_q.push_back('{addr: ADDR_W'(i), data: frame_w[i]});
        send_byte(frame_w[i][15:8]);
        send_byte(frame_w[i][7:0]);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        bus.byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic idle_bus(input int n);
        @(negedge clock);
        bus.byte_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic check_status(input string tag, input bit exp_done, input bit exp_err);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(exp_done));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        chk({tag, "_write_en"}, 32'(bus.write_en), 32'd0);
        chk({tag, "_write_select"}, 32'(bus.write_select), 32'd0);
        chk({tag, "_inp"}, 32'(bus.inp), 32'd0);
        check_status(tag, 1'b0, 1'b0);
    endtask

    // Full frame: length byte n, then (if n is legal) all words and checksum cs.
    task automatic load_frame(input string tag, input int n, input logic [7:0] cs);
        bit ok_len;
        bit exp_done;
        int wr0;
        ok_len = (n >= 1) && (n <= int'(MAX_WORDS));
        wr0    = wr_count;
        pulse_start();
        send_byte(n[7:0]);
        if (ok_len) begin
            for (int i = 0; i < n; i++) send_word(i);
            send_byte(cs);
        end
        idle_bus(2);
        exp_done = ok_len && (cs == ref_csum(n));
        check_status(tag, exp_done, !exp_done);
        chk({tag, "_writes"}, 32'(wr_count - wr0), ok_len ? 32'(n) : 32'd0);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic bad_len(input string tag, input logic [7:0] v);
        int wr0;
        wr0 = wr_count;
        pulse_start();
        send_byte(v);
        #1;
        chk({tag, "_err_next_cycle"}, 32'(error), 32'd1);
        idle_bus(3);
        check_status(tag, 1'b0, 1'b1);
        chk({tag, "_writes"}, 32'(wr_count - wr0), 32'd0);
    endtask

    initial begin
        int         n;
        logic [7:0] cs;

        n_vec = 0;
        n_err = 0;
        cyc = 0;
        wr_count = 0;
        gap_en = 1'b0;
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;

        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Directed image from the datasheet example.
        frame_w[0] = 16'h3000;
        frame_w[1] = 16'h8C09;
        load_frame("n2_good", 2, 8'hB5);
        load_frame("n2_badcs", 2, 8'h00);

        bad_len("len0", 8'd0);
        bad_len("len65", 8'd65);

        // Largest image, byte_valid held high, words must be 3 cycles apart.
        for (int i = 0; i < 64; i++) frame_w[i] = 16'($urandom);
        wr_cyc.delete();
        load_frame("n64", 64, ref_csum(64));
        chk("n64_strobes", 32'(wr_cyc.size()), 32'd64);
        for (int i = 1; i < wr_cyc.size(); i++) begin
            chk("n64_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd3);
        end

        // Abort after the high byte of word 5, together with start (abort wins).
        for (int i = 0; i < 8; i++) frame_w[i] = 16'($urandom);
        n = wr_count;
        pulse_start();
        send_byte(8'd8);
        for (int i = 0; i < 5; i++) send_word(i);
        send_byte(frame_w[5][15:8]);
        @(negedge clock);
        bus.byte_valid = 1'b0;
        abort = 1'b1;
        start = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        start = 1'b0;
        check_all_zero_status: begin
            chk("abort_ready", 32'(bus.byte_ready), 32'd0);
            chk("abort_write_en", 32'(bus.write_en), 32'd0);
            check_status("abort", 1'b0, 1'b0);
        end
        repeat (4) @(negedge clock);
        chk("abort_writes", 32'(wr_count - n), 32'd5);
        load_frame("after_abort", 3, ref_csum(3));
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check_status("abort_from_done", 1'b0, 1'b0);

        // Start while busy must not restart the address/word count.
        for (int i = 0; i < 4; i++) frame_w[i] = 16'($urandom);
        pulse_start();
        send_byte(8'd4);
        send_word(0);
        pulse_start();
        send_word(1);
        send_word(2);
        send_word(3);
        send_byte(ref_csum(4));
        idle_bus(2);
        check_status("start_busy", 1'b1, 1'b0);
        chk("start_busy_pending", 32'(exp_q.size()), 32'd0);

        // Reset mid-word: outputs clear immediately, CPU stays in reset.
        pulse_start();
        send_byte(8'd4);
        send_word(0);
        send_byte(frame_w[1][15:8]);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        chk("mid_reset_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clock);
        bus.byte_valid = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check_status("post_reset", 1'b0, 1'b0);

        // Randomized frames with stream bubbles, bad checksums and bad lengths.
        gap_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 5))
                0:       n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(65, 255));
                1:       n = int'($urandom_range(48, 64));
                default: n = int'($urandom_range(1, 16));
            endcase
            for (int i = 0; i < 64; i++) frame_w[i] = 16'($urandom);
            cs = (n <= 64) ? ref_csum(n) : 8'h00;
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            load_frame("rand", n, cs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
